pwm_counter: RTL
================

PWM_COUNTER -- requirements
Module: pwm_counter

Interface
REQ-001 The module SHALL have parameter PRESCALE_W, default 8, giving the prescale field width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-003 The module SHALL have port rst, input, 1 bit: reset is synchronous and active-high.
REQ-004 The module SHALL have port en, input, 1 bit: count enable.
REQ-005 The module SHALL have port period, input, 16 bits: last count value of a cycle, live/unbuffered.
REQ-006 The module SHALL have port prescale, input, PRESCALE_W bits: one count step per prescale+1 enabled clocks.
REQ-007 The module SHALL have port upnotdown, input, 1 bit: 1 = count up, 0 = count down.
REQ-008 The module SHALL have port count_reset, input, 1 bit: single-cycle restart request.
REQ-009 The module SHALL have port count_val, output, 16 bits: current count, fed to the PWM generator.
REQ-010 The module SHALL have port cycle_done, output, 1 bit: one-clock pulse at each period boundary.
REQ-011 The module SHALL have port running, output, 1 bit: high while the FSM is in RUN.

Function
REQ-012 Shadow registers sh_period, sh_prescale and sh_dir SHALL capture period, prescale and upnotdown only at a period boundary, on count_reset, or on an IDLE->RUN transition; mid-cycle input changes SHALL have no effect.
REQ-013 The FSM SHALL have two states. IDLE: count_val held, prescaler cleared. RUN: counting.
REQ-014 IDLE->RUN SHALL occur on the first clock with en=1, and that clock SHALL also load the shadows.
REQ-015 RUN->IDLE SHALL occur on the first clock with en=0; count_val SHALL hold its value (no clear); running SHALL follow the state with no extra latency.
REQ-016 The prescaler SHALL increment each RUN clock; when it equals sh_prescale it SHALL clear to 0 and generate a step tick. Step period is sh_prescale+1 clocks; sh_prescale=0 means a step every clock.
REQ-017 For an up-count step (sh_dir=1): if count_val >= sh_period, count_val SHALL become 0 and this is a boundary; otherwise count_val SHALL increment by 1.
REQ-018 For a down-count step (sh_dir=0): if count_val == 0, the shadows SHALL reload and count_val SHALL load the newly latched period value, and this is a boundary; otherwise count_val SHALL decrement by 1.
REQ-019 The >= comparison in REQ-017 SHALL ensure a shrunk period cannot leave count_val above sh_period beyond one step.
REQ-020 cycle_done SHALL be registered and high exactly one clock, the clock after the boundary step, so it coincides with the new cycle start value on count_val.
REQ-021 With sh_period=0, count_val SHALL stay 0 and cycle_done SHALL pulse on every step tick.
REQ-022 count_reset=1 SHALL, in the next clock and regardless of state: clear the prescaler, reload the shadows, set count_val to 0 (new dir up) or to the period input value (new dir down), and leave cycle_done low. In IDLE it SHALL update count_val without starting counting.
REQ-023 Priority SHALL be rst > count_reset > en/FSM > step logic.
REQ-024 All arithmetic SHALL be 16-bit unsigned with no wrap other than REQ-017/018; 0xFFFF is a legal period.

Reset
REQ-025 While rst=1 at a clock edge: count_val=0, cycle_done=0, running=0, FSM=IDLE, prescaler=0, sh_period=0, sh_prescale=0, sh_dir=1.
REQ-026 Reset asserted mid-cycle SHALL take effect at that edge with no completion pulse; counting SHALL resume only under REQ-014 after rst deasserts.

Verification
REQ-027 Up-count wrap: period=3, prescale=0, up, en=1 -> count_val 0,1,2,3,0,1…; cycle_done high with each 0 after 3.
REQ-028 Prescale: period=2, prescale=2 -> each value held 3 clocks; sequence 0,0,0,1,1,1,2,2,2,0.
REQ-029 Down-count: period=4, down -> 0,4,3,2,1,0,4…; cycle_done coincides with each 4.
REQ-030 Shadowing: period=5; change to 2 when count_val=1 -> 2..5 finish, then 0,1,2,0; change to 7 mid-cycle -> takes effect only after the boundary.
REQ-031 Enable/reset: drop en at count_val=3 -> holds 3 with running=0; re-enable -> continues to 4. count_reset at count_val=4 -> next clock 0, no cycle_done pulse.
REQ-032 Sync reset: rst pulsed at count_val=9 -> next clock count_val=0, running=0, cycle_done=0; with en held high, count resumes one clock after rst is released.

Source files
------------

// File: rtl/pwm_counter.sv
// rtl/pwm_counter.sv - prescaled up/down period counter feeding a PWM generator
//
// Purpose: counts 0..period (up) or period..0 (down), one step every
// prescale+1 enabled clocks, with period/prescale/direction shadowed so that
// changes only take effect at a cycle boundary, on a restart, or on start.
//
// Ports:
//   clk          - single rising-edge clock
//   rst          - synchronous active-high reset
//   en           - count enable; starts (IDLE->RUN) and stops (RUN->IDLE) the FSM
//   period       - last count value of a cycle (sampled into the shadow)
//   prescale     - one count step per prescale+1 enabled clocks (shadowed)
//   upnotdown    - 1 = count up, 0 = count down (shadowed)
//   count_reset  - single-cycle restart request
//   count_val    - current count
//   cycle_done   - one-clock pulse aligned with the first value of a new cycle
//   running      - high while the FSM is in RUN

module pwm_counter #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [15:0]           period,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  upnotdown,
    input  logic                  count_reset,
    output logic [15:0]           count_val,
    output logic                  cycle_done,
    output logic                  running
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [15:0]           r_count;
    logic                  r_cycle_done;
    logic [PRESCALE_W-1:0] r_prescaler;
    logic [15:0]           r_sh_period;
    logic [PRESCALE_W-1:0] r_sh_prescale;
    logic                  r_sh_dir;

    logic                  w_tick;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a restart request holds the current state
    always_comb begin
        w_state_next = r_state;
        if (!count_reset) begin
            case (r_state)
                S_IDLE:  if (en)  w_state_next = S_RUN;
                S_RUN:   if (!en) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        running = (r_state == S_RUN);
    end

    assign count_val  = r_count;
    assign cycle_done = r_cycle_done;

    // A step happens on the RUN clock where the prescaler reaches its shadow limit
    assign w_tick = (r_state == S_RUN) && en && (r_prescaler == r_sh_prescale);

    // Counter, prescaler and shadow datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count       <= 16'd0;
            r_cycle_done  <= 1'b0;
            r_prescaler   <= '0;
            r_sh_period   <= 16'd0;
            r_sh_prescale <= '0;
            r_sh_dir      <= 1'b1;
        end else begin
            r_cycle_done <= 1'b0;
            if (count_reset) begin
                r_prescaler   <= '0;
                r_sh_period   <= period;
                r_sh_prescale <= prescale;
                r_sh_dir      <= upnotdown;
                r_count       <= upnotdown ? 16'd0 : period;
            end else if (r_state == S_IDLE) begin
                r_prescaler <= '0;
                if (en) begin
                    r_sh_period   <= period;
                    r_sh_prescale <= prescale;
                    r_sh_dir      <= upnotdown;
                end
            end else if (!en) begin
                r_prescaler <= '0;
            end else if (w_tick) begin
                r_prescaler <= '0;
                if (r_sh_dir) begin
                    // >= so a period shrunk below the count wraps on the next step
                    if (r_count >= r_sh_period) begin
                        r_count       <= 16'd0;
                        r_cycle_done  <= 1'b1;
                        r_sh_period   <= period;
                        r_sh_prescale <= prescale;
                        r_sh_dir      <= upnotdown;
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end else begin
                    // Down wrap reloads from the freshly latched period
                    if (r_count == 16'd0) begin
                        r_count       <= period;
                        r_cycle_done  <= 1'b1;
                        r_sh_period   <= period;
                        r_sh_prescale <= prescale;
                        r_sh_dir      <= upnotdown;
                    end else begin
                        r_count <= r_count - 16'd1;
                    end
                end
            end else begin
                r_prescaler <= r_prescaler + PRESCALE_W'(1);
            end
        end
    end

endmodule
